// File: rtl/tail_lamp_pkg.sv
// Shared types and lamp patterns for the rear turn/hazard lamp controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tail_lamp_pkg;

  // Sequence states. Lx/Rx light x lamps, counting outward from the innermost.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    HAZ  = 3'd7
  } state_t;

  // Lamp patterns in [0:2] order: the leftmost literal bit is the innermost lamp.
  localparam logic [0:2] OFF = 3'b000;
  localparam logic [0:2] ONE = 3'b100;
  localparam logic [0:2] TWO = 3'b110;
  localparam logic [0:2] ALL = 3'b111;

endpackage

// File: rtl/tail_lamp_prescaler.sv
// Step pulse generator: step is high for one cycle every STEP_CYCLES cycles.
// Latency: the first step comes STEP_CYCLES cycles after reset release (every cycle when STEP_CYCLES=1).
// Backpressure: none; free-running.
// Ports: clk, rst (async active-low), step (combinational decode of the counter register).
module tail_lamp_prescaler #(
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  output logic step
);

  // A 1-bit counter is kept even for STEP_CYCLES=1; it simply stays at 0.
  localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  assign step = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/tail_lamp_ctrl.sv
// Thunderbird-style rear lamp controller: outward turn sequences on LI/RI, all-six hazard flash.
// Latency: inputs sampled on a step edge show on LI/RI right after that edge; no comb input->output path
//          (except the brake overlay when TAIL_LAMP_BRAKE_EN is defined).
// Backpressure: none; the state advances only on prescaler steps.
// Ports: clk, rst (async active-low), E (hazard), TL/TR (turn requests), [BRK (brake, only with
//        TAIL_LAMP_BRAKE_EN)], LI/RI [0:2] lamp outputs with index 0 innermost.
module tail_lamp_ctrl
  import tail_lamp_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       E,
  input  logic       TL,
  input  logic       TR,
`ifdef TAIL_LAMP_BRAKE_EN
  input  logic       BRK,
`endif
  output logic [0:2] LI,
  output logic [0:2] RI
);

  logic       step;
  state_t     state_q, state_d;
  logic [0:2] li_q, li_d;
  logic [0:2] ri_q, ri_d;

  tail_lamp_prescaler #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .step(step)
  );

  // Next state and the lamp patterns of that state; the patterns are
  // registered alongside the state so the outputs come straight from flops.
  always_comb begin
    state_d = state_q;
    li_d    = OFF;
    ri_d    = OFF;

    if (step) begin
      case (state_q)
        IDLE: begin
          if (E || (TL && TR)) state_d = HAZ;
          else if (TL)         state_d = L1;
          else if (TR)         state_d = R1;
          else                 state_d = IDLE;
        end
        // A started sequence runs to completion unless hazard pre-empts it.
        L1:      state_d = E ? HAZ : L2;
        L2:      state_d = E ? HAZ : L3;
        L3:      state_d = E ? HAZ : IDLE;
        R1:      state_d = E ? HAZ : R2;
        R2:      state_d = E ? HAZ : R3;
        R3:      state_d = E ? HAZ : IDLE;
        // Always passes through IDLE, so a held E flashes all-on/all-off.
        HAZ:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    case (state_d)
      L1:      li_d = ONE;
      L2:      li_d = TWO;
      L3:      li_d = ALL;
      R1:      ri_d = ONE;
      R2:      ri_d = TWO;
      R3:      ri_d = ALL;
      HAZ: begin
        li_d = ALL;
        ri_d = ALL;
      end
      default: begin
        li_d = OFF;
        ri_d = OFF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      li_q    <= OFF;
      ri_q    <= OFF;
    end else begin
      state_q <= state_d;
      li_q    <= li_d;
      ri_q    <= ri_d;
    end
  end

`ifdef TAIL_LAMP_BRAKE_EN
  logic left_seq;
  logic right_seq;

  assign left_seq  = (state_q == L1) || (state_q == L2) || (state_q == L3);
  assign right_seq = (state_q == R1) || (state_q == R2) || (state_q == R3);

  // Brake lights every side that is not running a turn sequence; hazard
  // flashing is left untouched so it stays recognisable.
  always_comb begin
    LI = li_q;
    RI = ri_q;
    if (BRK && (state_q != HAZ)) begin
      if (!left_seq)  LI = ALL;
      if (!right_seq) RI = ALL;
    end
  end
`else
  assign LI = li_q;
  assign RI = ri_q;
`endif

endmodule

// File: tb/tb_tail_lamp_ctrl.sv
module tb_tail_lamp_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic E   = 1'b0;
  logic TL  = 1'b0;
  logic TR  = 1'b0;
`ifdef TAIL_LAMP_BRAKE_EN
  logic BRK = 1'b0;
`endif
  logic [0:2] li1, ri1, li4, ri4;

  always #5 clk = ~clk;

  tail_lamp_ctrl #(.STEP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .E(E), .TL(TL), .TR(TR),
`ifdef TAIL_LAMP_BRAKE_EN
    .BRK(BRK),
`endif
    .LI(li1), .RI(ri1)
  );

  tail_lamp_ctrl #(.STEP_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .E(E), .TL(TL), .TR(TR),
`ifdef TAIL_LAMP_BRAKE_EN
    .BRK(BRK),
`endif
    .LI(li4), .RI(ri4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model, per instance: mode 0=idle 1=left 2=right 3=hazard,
  // lit = how many lamps of the active side are on, cnt = cycles into the step.
  int mode [2];
  int lit  [2];
  int cnt  [2];
  int step_cfg [2];

  function automatic logic [0:2] fill(input int n);
    logic [0:2] v;
    for (int i = 0; i < 3; i++) v[i] = (i < n);
    return v;
  endfunction

  // side 0 = left, 1 = right
  function automatic logic [0:2] expect_lamps(input int k, input int side);
    logic [0:2] v;
    if (mode[k] == 3)             v = 3'b111;
    else if (mode[k] == side + 1) v = fill(lit[k]);
    else                          v = 3'b000;
`ifdef TAIL_LAMP_BRAKE_EN
    if (BRK && mode[k] != 3 && mode[k] != side + 1) v = 3'b111;
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0;
      lit[k]  = 0;
      cnt[k]  = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (cnt[k] == step_cfg[k] - 1) begin
        cnt[k] = 0;
        if (mode[k] == 3) begin
          mode[k] = 0;
        end else if (mode[k] != 0) begin
          if (E) mode[k] = 3;
          else if (lit[k] == 3) begin
            mode[k] = 0;
            lit[k]  = 0;
          end else lit[k] = lit[k] + 1;
        end else begin
          if (E || (TL && TR)) mode[k] = 3;
          else if (TL) begin mode[k] = 1; lit[k] = 1; end
          else if (TR) begin mode[k] = 2; lit[k] = 1; end
        end
      end else begin
        cnt[k] = cnt[k] + 1;
      end
    end
  endtask

  // Advance one clock: the model sees the same inputs the DUTs sampled.
  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #2;
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (!v) model_reset();
  endtask

  task automatic chk(input string name, input logic [0:2] act, input logic [0:2] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("li1_model", li1, expect_lamps(0, 0));
      chk("ri1_model", ri1, expect_lamps(0, 1));
      chk("li4_model", li4, expect_lamps(1, 0));
      chk("ri4_model", ri4, expect_lamps(1, 1));
    end
  end

  logic [0:2] pat [4];

  initial begin
    step_cfg[0] = 1;
    step_cfg[1] = 4;
    pat[0] = 3'b100; pat[1] = 3'b110; pat[2] = 3'b111; pat[3] = 3'b000;
    model_reset();
    TL = 1'b1;
    #1 set_rst(1'b0);

    // Reset held with TL requested.
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      chk("rst_li", li1, 3'b000);
      chk("rst_ri", ri1, 3'b000);
    end
    set_rst(1'b1);

    // Sustained left turn, both step rates.
    for (int k = 1; k <= 12; k++) begin
      tick(); #1;
      chk("left_li1", li1, pat[(k - 1) % 4]);
      chk("left_ri1", ri1, 3'b000);
      chk("left_li4", li4, (k < 4) ? 3'b000 : (k < 8) ? 3'b100 : (k < 12) ? 3'b110 : 3'b111);
    end
    tick(); #1; chk("left_l1", li1, 3'b100);
    tick(); #1; chk("left_l2", li1, 3'b110);
    TL = 1'b0;
    tick(); #1; chk("drop_l3", li1, 3'b111);
    tick(); #1; chk("drop_idle", li1, 3'b000);
    tick(); #1; chk("drop_hold", li1, 3'b000);

    // Hazard beats a turn request from IDLE and alternates.
    TL = 1'b1; E = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick(); #1;
      chk("haz_li", li1, (j % 2 == 0) ? 3'b111 : 3'b000);
      chk("haz_ri", ri1, (j % 2 == 0) ? 3'b111 : 3'b000);
    end
    TL = 1'b0; E = 1'b0;
    tick(); #1; chk("haz_off", li1, 3'b000);

    // Hazard pre-empts a running left sequence.
    TL = 1'b1;
    tick(); #1; chk("pre_l1", li1, 3'b100);
    TL = 1'b0; E = 1'b1;
    tick(); #1; chk("pre_haz_li", li1, 3'b111); chk("pre_haz_ri", ri1, 3'b111);
    E = 1'b0;
    tick(); #1; chk("pre_idle", li1, 3'b000);

    // Both turn requests together act as hazard.
    TL = 1'b1; TR = 1'b1;
    tick(); #1; chk("both_li", li1, 3'b111); chk("both_ri", ri1, 3'b111);
    TL = 1'b0; TR = 1'b0;
    tick(); #1; chk("both_off", ri1, 3'b000);

    // Sustained right turn.
    TR = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(); #1;
      chk("right_ri1", ri1, pat[(k - 1) % 4]);
      chk("right_li1", li1, 3'b000);
    end
    TR = 1'b0;
    tick(); #1; chk("right_off", ri1, 3'b000);

`ifdef TAIL_LAMP_BRAKE_EN
    BRK = 1'b1;
    #1; chk("brk_idle_li", li1, 3'b111); chk("brk_idle_ri", ri1, 3'b111);
    TL = 1'b1;
    tick(); #1; chk("brk_l1_li", li1, 3'b100); chk("brk_l1_ri", ri1, 3'b111);
    tick(); #1; chk("brk_l2_li", li1, 3'b110); chk("brk_l2_ri", ri1, 3'b111);
    TL = 1'b0; BRK = 1'b0;
    tick(); tick(); tick();
`endif

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 3) == 0) begin
        E  = ($urandom_range(0, 5) == 0);
        TL = ($urandom_range(0, 2) == 0);
        TR = ($urandom_range(0, 2) == 0);
      end
`ifdef TAIL_LAMP_BRAKE_EN
      if ($urandom_range(0, 7) == 0) BRK = ~BRK;
`endif
      if (!rst) set_rst(1'b1);
      else if ($urandom_range(0, 199) == 0) set_rst(1'b0);
    end

    set_rst(1'b1);
    E = 1'b0; TL = 1'b0; TR = 1'b0;
    tick(); tick();
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
